// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix storage access path.
// - Requester indices used on the req/done/gnt/start_pulse vectors.
// - Arbiter FSM state encoding.
// - Slot mapping helpers for the three round-robin requesters
//   (INPUT, GEN, DISP), which occupy slots 0, 1, 2 of the rotation.
package matrix_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] REQ_INPUT  = 2'd0;
    localparam logic [1:0] REQ_GEN    = 2'd1;
    localparam logic [1:0] REQ_RESULT = 2'd2;
    localparam logic [1:0] REQ_DISP   = 2'd3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_GRANT    = 2'd1;
    localparam state_t ST_BUSY     = 2'd2;
    localparam state_t ST_COOLDOWN = 2'd3;

    // Rotation slot -> requester index (slot 2 is DISP, skipping RESULT).
    function automatic logic [1:0] slot_to_id(input logic [1:0] slot);
        return (slot == 2'd2) ? REQ_DISP : slot;
    endfunction

    // Requester index -> rotation slot; only INPUT, GEN and DISP are ever passed.
    function automatic logic [1:0] id_to_slot(input logic [1:0] id);
        return (id == REQ_DISP) ? 2'd2 : id;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker over the three non-RESULT requesters.
// Ports:
//   req_slot  in  3  requests by rotation slot {DISP, GEN, INPUT}
//   rr_ptr    in  2  requester index of the previous round-robin winner
//   valid     out 1  some slot is requesting
//   winner    out 2  requester index of the first requesting slot after rr_ptr
module rr_pick3
    import matrix_pkg::*;
(
    input  logic [2:0] req_slot,
    input  logic [1:0] rr_ptr,
    output logic       valid,
    output logic [1:0] winner
);

    logic [1:0] cand;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        valid  = 1'b0;
        winner = REQ_INPUT;
        cand   = id_to_slot(rr_ptr);
        // Walk the three slots starting just after the previous winner.
        for (int i = 0; i < 3; i++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!valid && req_slot[cand]) begin
                valid  = 1'b1;
                winner = slot_to_id(cand);
            end
        end
    end

endmodule

// File: rtl/matrix_access_arbiter.sv
// Single-owner arbiter for the matrix storage sequencers.
// Grants one of four requesters (INPUT, GEN, RESULT, DISP), strobes its
// storage start for one cycle, holds the grant until the owner's done or a
// timeout, then idles for a cooldown so the storage slot search settles.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req[3:0]         level requests (0 INPUT, 1 GEN, 2 RESULT, 3 DISP)
//   done[3:0]        completion pulses; only the owner's bit is honoured
//   clear_err        clears timeout_err (a coincident timeout wins)
//   gnt[3:0]         one-hot grant, zero when not owned
//   gnt_id[1:0]      encoded owner, valid while gnt != 0
//   start_pulse[3:0] one-cycle strobe toward storage in the GRANT cycle
//   busy             high in GRANT, BUSY and COOLDOWN
//   timeout_err      sticky timeout flag
//   timeout_id[1:0]  owner at the last timeout
module matrix_access_arbiter
    import matrix_pkg::*;
#(
    parameter int TIMEOUT_CYC    = 4096,
    parameter int COOLDOWN_CYC   = 2,
    parameter int MAX_RES_STREAK = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    input  logic               clear_err,
    output logic [NUM_REQ-1:0] gnt,
    output logic [1:0]         gnt_id,
    output logic [NUM_REQ-1:0] start_pulse,
    output logic               busy,
    output logic               timeout_err,
    output logic [1:0]         timeout_id
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam int CD_W  = $clog2(COOLDOWN_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN_CYC - 1);
    // The streak saturates at the limit, so "== limit" also covers longer runs.
    localparam logic [1:0] STREAK_CAP = (MAX_RES_STREAK > 3) ? 2'd3 : 2'(MAX_RES_STREAK);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]         gnt_id_q, gnt_id_d;
    logic [NUM_REQ-1:0] start_pulse_q, start_pulse_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;
    logic [1:0]         timeout_id_q, timeout_id_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         res_streak_q, res_streak_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CD_W-1:0]    cd_cnt_q, cd_cnt_d;
    logic               done_seen_q, done_seen_d;

    logic       rr_valid;
    logic [1:0] rr_winner;
    logic       others_req, res_win, grant_ok, done_hit, tmo_hit;
    logic [1:0] win_id;

    rr_pick3 u_rr_pick3 (
        .req_slot ({req[REQ_DISP], req[REQ_GEN], req[REQ_INPUT]}),
        .rr_ptr   (rr_ptr_q),
        .valid    (rr_valid),
        .winner   (rr_winner)
    );

    assign others_req = req[REQ_INPUT] | req[REQ_GEN] | req[REQ_DISP];
    assign res_win    = req[REQ_RESULT] & ~((res_streak_q == STREAK_CAP) & others_req);
    assign grant_ok   = res_win | rr_valid;
    assign win_id     = res_win ? REQ_RESULT : rr_winner;
    // A done seen during GRANT is remembered so BUSY exits on its first cycle.
    assign done_hit   = done[gnt_id_q] | done_seen_q;
    assign tmo_hit    = (tmo_cnt_q == TMO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (grant_ok) state_d = ST_GRANT;
            ST_GRANT:    state_d = ST_BUSY;
            ST_BUSY:     if (done_hit || tmo_hit) state_d = ST_COOLDOWN;
            ST_COOLDOWN: if (cd_cnt_q == '0) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output and bookkeeping logic; all outputs leave through flops.
    always_comb begin
        gnt_d         = gnt_q;
        gnt_id_d      = gnt_id_q;
        start_pulse_d = '0;
        busy_d        = (state_d != ST_IDLE);
        timeout_err_d = timeout_err_q & ~clear_err;
        timeout_id_d  = timeout_id_q;
        rr_ptr_d      = rr_ptr_q;
        res_streak_d  = res_streak_q;
        tmo_cnt_d     = tmo_cnt_q;
        cd_cnt_d      = cd_cnt_q;
        done_seen_d   = done_seen_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    gnt_d         = NUM_REQ'(1) << win_id;
                    gnt_id_d      = win_id;
                    start_pulse_d = NUM_REQ'(1) << win_id;
                    done_seen_d   = 1'b0;
                    if (res_win) begin
                        if (res_streak_q != STREAK_CAP) res_streak_d = res_streak_q + 2'd1;
                    end else begin
                        res_streak_d = 2'd0;
                        rr_ptr_d     = rr_winner;
                    end
                end
            end
            ST_GRANT: begin
                tmo_cnt_d   = '0;
                done_seen_d = done[gnt_id_q];
            end
            ST_BUSY: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (done_hit || tmo_hit) begin
                    gnt_d    = '0;
                    cd_cnt_d = CD_LOAD;
                end
                // Setting after the clear above lets a coincident timeout win.
                if (!done_hit && tmo_hit) begin
                    timeout_err_d = 1'b1;
                    timeout_id_d  = gnt_id_q;
                end
            end
            ST_COOLDOWN: begin
                if (cd_cnt_q != '0) cd_cnt_d = cd_cnt_q - CD_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q         <= '0;
            gnt_id_q      <= REQ_INPUT;
            start_pulse_q <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            timeout_id_q  <= 2'd0;
            rr_ptr_q      <= REQ_DISP;
            res_streak_q  <= 2'd0;
            tmo_cnt_q     <= '0;
            cd_cnt_q      <= '0;
            done_seen_q   <= 1'b0;
        end else begin
            gnt_q         <= gnt_d;
            gnt_id_q      <= gnt_id_d;
            start_pulse_q <= start_pulse_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            timeout_id_q  <= timeout_id_d;
            rr_ptr_q      <= rr_ptr_d;
            res_streak_q  <= res_streak_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cd_cnt_q      <= cd_cnt_d;
            done_seen_q   <= done_seen_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign start_pulse = start_pulse_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign timeout_id  = timeout_id_q;

endmodule
